// File: rtl/led_pattern_if.sv
// led_pattern_if
//   Board-facing signal bundle of the LED pattern generator.
//   Signals:
//     key  - raw asynchronous push-button level from the pin
//     led  - LED drive, LEDS_NR bits, 1 = on
//     mode - current display mode (0 COUNT, 1 SCAN, 2 BREATHE, 3 HOLD)
//     tick - one-cycle pattern step strobe (debug)
//   There is no handshake on this bundle: key is a free-running level that
//   the generator synchronises and debounces itself, and led/mode/tick are
//   plain registered levels valid every cycle.
//   Modports:
//     master - the board/pin side: drives key, observes the outputs
//     slave  - the generator: samples key, drives led/mode/tick
interface led_pattern_if #(
    parameter int LEDS_NR = 6
);
    logic               key;
    logic [LEDS_NR-1:0] led;
    logic [1:0]         mode;
    logic               tick;

    modport master (output key, input led, input mode, input tick);
    modport slave  (input key, output led, output mode, output tick);
endinterface

// File: rtl/led_pattern_gen.sv
// led_pattern_gen
//   LED pattern generator for board bring-up. A prescaler produces a step
//   tick every TICK_DIV cycles; a debounced key cycles through four display
//   modes: binary count, bouncing scanner, PWM breathe and hold.
//   Ports:
//     clk - sole clock (oscillator output)
//     rst - synchronous active-high reset, priority over everything
//     io  - led_pattern_if.slave: key in; led, mode, tick out
//   The mode register doubles as the exposed FSM state (io.mode).
//   led is registered from the pattern state of the previous edge, so a
//   state change shows on the pins one cycle later.
module led_pattern_gen #(
    parameter int LEDS_NR         = 6,
    parameter int TICK_DIV        = 1048576,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int PWM_W           = 8,
    parameter bit KEY_ACTIVE_LOW  = 1'b0
) (
    input logic          clk,
    input logic          rst,
    led_pattern_if.slave io
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int POS_W  = (LEDS_NR > 1) ? $clog2(LEDS_NR) : 1;

    localparam logic [TICK_W-1:0]  TICK_LAST    = TICK_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0]  TICK_PRE     = TICK_W'(TICK_DIV - 2);
    localparam logic [TICK_W-1:0]  TICK_ONE     = TICK_W'(1);
    localparam logic [DEB_W-1:0]   DEB_LAST     = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_W-1:0]   DEB_ONE      = DEB_W'(1);
    localparam logic               KEY_REL      = KEY_ACTIVE_LOW;
    localparam logic [POS_W-1:0]   POS_ONE      = POS_W'(1);
    // Position from which one more step up lands on the last LED.
    localparam logic [POS_W-1:0]   POS_TURN_UP  = POS_W'((LEDS_NR > 1) ? LEDS_NR - 2 : 0);
    localparam logic [PWM_W-1:0]   PWM_ONE      = PWM_W'(1);
    // Duty from which one more step up lands on full scale.
    localparam logic [PWM_W-1:0]   DUTY_TURN_UP = {{(PWM_W-1){1'b1}}, 1'b0};
    localparam logic [LEDS_NR-1:0] LED_ONE      = LEDS_NR'(1);
    localparam logic [LEDS_NR-1:0] STEP_ONE     = LEDS_NR'(1);

    typedef enum logic [1:0] {
        MODE_COUNT   = 2'd0,
        MODE_SCAN    = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_HOLD    = 2'd3
    } mode_e;

    // ---------------- tick prescaler ----------------
    logic [TICK_W-1:0] tick_cnt;
    logic              tick_q;

    // tick_q is raised on the edge that moves the counter to TICK_DIV-1, so
    // it is high exactly while the counter holds its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            tick_q   <= 1'b0;
        end else begin
            tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TICK_ONE;
            tick_q   <= (tick_cnt == TICK_PRE);
        end
    end

    // ---------------- key synchroniser + debounce ----------------
    logic             key_s1;
    logic             key_s2;
    logic             key_lvl;   // synchronised level, 1 = pressed
    logic             key_acc;   // accepted level, 1 = pressed
    logic [DEB_W-1:0] deb_cnt;
    logic             deb_done;
    logic             press_evt;

    assign key_lvl   = key_s2 ^ KEY_REL;
    // Last differing sample of a full stable run: accept it this edge.
    assign deb_done  = (key_lvl != key_acc) && (deb_cnt == DEB_LAST);
    assign press_evt = deb_done && key_lvl;

    always_ff @(posedge clk) begin
        if (rst) begin
            key_s1  <= KEY_REL;
            key_s2  <= KEY_REL;
            key_acc <= 1'b0;
            deb_cnt <= '0;
        end else begin
            key_s1 <= io.key;
            key_s2 <= key_s1;
            if (key_lvl == key_acc) begin
                deb_cnt <= '0;
            end else if (deb_done) begin
                deb_cnt <= '0;
                key_acc <= key_lvl;
            end else begin
                deb_cnt <= deb_cnt + DEB_ONE;
            end
        end
    end

    // ---------------- mode FSM + pattern state ----------------
    mode_e              mode_q,    mode_d;
    logic [LEDS_NR-1:0] step_q,    step_d;
    logic [POS_W-1:0]   pos_q,     pos_d;
    logic               scan_up_q, scan_up_d;
    logic [PWM_W-1:0]   duty_q,    duty_d;
    logic               duty_up_q, duty_up_d;
    logic [PWM_W-1:0]   pwm_q;
    logic [LEDS_NR-1:0] led_q,     led_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= MODE_COUNT;
            step_q    <= '0;
            pos_q     <= '0;
            scan_up_q <= 1'b1;
            duty_q    <= '0;
            duty_up_q <= 1'b1;
            pwm_q     <= '0;
            led_q     <= '0;
        end else begin
            mode_q    <= mode_d;
            step_q    <= step_d;
            pos_q     <= pos_d;
            scan_up_q <= scan_up_d;
            duty_q    <= duty_d;
            duty_up_q <= duty_up_d;
            pwm_q     <= pwm_q + PWM_ONE;
            led_q     <= led_d;
        end
    end

    always_comb begin
        mode_d    = mode_q;
        step_d    = step_q;
        pos_d     = pos_q;
        scan_up_d = scan_up_q;
        duty_d    = duty_q;
        duty_up_d = duty_up_q;

        if (press_evt) begin
            // A press on a tick edge takes precedence: the new mode starts
            // from its cleared state and the tick is dropped.
            mode_d = mode_e'(mode_q + 2'd1);
            case (mode_d)
                MODE_COUNT: step_d = '0;
                MODE_SCAN: begin
                    pos_d     = '0;
                    scan_up_d = 1'b1;
                end
                MODE_BREATHE: begin
                    duty_d    = '0;
                    duty_up_d = 1'b1;
                end
                default: ;
            endcase
        end else if (tick_q) begin
            case (mode_q)
                MODE_COUNT: step_d = step_q + STEP_ONE;
                MODE_SCAN: begin
                    // Turn around as soon as an end is reached, so the end
                    // LEDs stay lit for one step only.
                    if (LEDS_NR > 1) begin
                        if (scan_up_q) begin
                            pos_d = pos_q + POS_ONE;
                            if (pos_q == POS_TURN_UP) scan_up_d = 1'b0;
                        end else begin
                            pos_d = pos_q - POS_ONE;
                            if (pos_q == POS_ONE) scan_up_d = 1'b1;
                        end
                    end
                end
                MODE_BREATHE: begin
                    if (duty_up_q) begin
                        duty_d = duty_q + PWM_ONE;
                        if (duty_q == DUTY_TURN_UP) duty_up_d = 1'b0;
                    end else begin
                        duty_d = duty_q - PWM_ONE;
                        if (duty_q == PWM_ONE) duty_up_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // led follows the registered mode/state; HOLD freezes whatever was shown.
    always_comb begin
        led_d = led_q;
        case (mode_q)
            MODE_COUNT:   led_d = step_q;
            MODE_SCAN:    led_d = LED_ONE << pos_q;
            MODE_BREATHE: led_d = {LEDS_NR{pwm_q < duty_q}};
            default:      led_d = led_q;
        endcase
    end

    assign io.led  = led_q;
    assign io.mode = mode_q;
    assign io.tick = tick_q;

endmodule
